// File: rtl/memctrl_pkg.sv
// memctrl_pkg: types shared by the banked memory controller and its banks
package memctrl_pkg;
    localparam int MAX_AW = 32;
    localparam int MAX_DW = 64;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RECOVER} state_e;
    typedef enum logic {CMD_RD, CMD_WR} cmd_e;
    typedef struct packed {
        cmd_e              typ;
        logic [MAX_AW-1:0] addr;
        logic [MAX_DW-1:0] data;
    } entry_t;
endpackage

// File: rtl/memctrl_bank.sv
// memctrl_bank: single-port DW x 2^RW storage bank with registered read port
module memctrl_bank #(
    parameter int DW = 8,
    parameter int RW = 14
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          we,
    input  logic          re,
    input  logic [RW-1:0] row,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**RW];
    logic [DW-1:0] rdata_q, rdata_d;

    assign rdata = rdata_q;

    always_comb rdata_d = re ? mem[row] : rdata_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    // Storage is deliberately not reset so contents survive RSTN.
    always_ff @(posedge CLK) begin
        if (we) mem[row] <= wdata;
    end
endmodule

// File: rtl/memctrl_banked.sv
// memctrl_banked: in-order command queue issuing reads/writes to NBANK banks, one bubble on same-bank back-to-back
module memctrl_banked
    import memctrl_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 16,
    parameter int NBANK  = 4,
    parameter int QDEPTH = 2
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic [AW-1:0] ADDR,
    input  logic          CE,
    input  logic          CSB,
    input  logic          WEB,
    input  logic          OEB,
    input  logic [DW-1:0] IDATA,
    output logic          RDY,
    output logic [DW-1:0] ODATA,
    output logic          ODATA_VLD,
    output logic          ERR
);
    localparam int BW = $clog2(NBANK);
    localparam int RW = AW - BW;
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    entry_t        fifo_q [QDEPTH];
    entry_t        push_entry;
    logic [PW-1:0] rd_q, rd_d, rd_nx, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q, state_d;
    logic          err_q, err_d, vld_q, vld_d, pend_q, pend_d;
    logic [DW-1:0] odata_q, odata_d, h_data;
    logic [BW-1:0] pbank_q, pbank_d, h_bank, nh_bank;
    logic [RW-1:0] h_row;
    logic          h_wr, cmd_ok, push, issue;
    logic [DW-1:0] bank_rdata [NBANK];

    assign RDY       = RSTN && (count_q != CW'(QDEPTH));
    assign ODATA     = odata_q;
    assign ODATA_VLD = vld_q;
    assign ERR       = err_q;

    always_comb begin
        cmd_ok          = CE && !CSB && RDY;
        push            = cmd_ok && (WEB != OEB);
        err_d           = cmd_ok && !WEB && !OEB;
        push_entry      = '{typ: WEB ? CMD_RD : CMD_WR, addr: MAX_AW'(ADDR), data: MAX_DW'(IDATA)};
        issue           = state_q == ST_ISSUE;
        h_wr            = fifo_q[rd_q].typ == CMD_WR;
        {h_bank, h_row} = fifo_q[rd_q].addr[AW-1:0];
        h_data          = fifo_q[rd_q].data[DW-1:0];
        rd_nx           = (rd_q == PW'(QDEPTH - 1)) ? '0 : rd_q + 1'b1;
        rd_d            = issue ? rd_nx : rd_q;
        wr_d            = !push ? wr_q : (wr_q == PW'(QDEPTH - 1)) ? '0 : wr_q + 1'b1;
        count_d         = count_q + CW'(push) - CW'(issue);
        // With a single queued entry the next head is the one being pushed this cycle.
        nh_bank         = (count_q > CW'(1)) ? fifo_q[rd_nx].addr[AW-1 -: BW] : ADDR[AW-1 -: BW];
        state_d         = (count_d == '0) ? ST_IDLE :
                          (issue && nh_bank == h_bank) ? ST_RECOVER : ST_ISSUE;
        pend_d          = issue && !h_wr;
        pbank_d         = h_bank;
        vld_d           = pend_q;
        odata_d         = pend_q ? bank_rdata[pbank_q] : odata_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            pend_q  <= 1'b0;
            pbank_q <= '0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            pend_q  <= pend_d;
            pbank_q <= pbank_d;
            odata_q <= odata_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_q[wr_q] <= push_entry;
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        memctrl_bank #(.DW(DW), .RW(RW)) u_bank (
            .CLK   (CLK),
            .RSTN  (RSTN),
            .we    (issue && h_wr && h_bank == BW'(b)),
            .re    (issue && !h_wr && h_bank == BW'(b)),
            .row   (h_row),
            .wdata (h_data),
            .rdata (bank_rdata[b])
        );
    end
endmodule

// File: tb/tb_memctrl_banked.sv
// tb_memctrl_banked: directed and random stimulus against a schedule-based reference model
module tb_memctrl_banked;
    localparam int QDEPTH = 2;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [15:0] ADDR = '0;
    logic        CE = 1'b0, CSB = 1'b1, WEB = 1'b1, OEB = 1'b1;
    logic [7:0]  IDATA = '0;
    logic        RDY, ODATA_VLD, ERR;
    logic [7:0]  ODATA;

    memctrl_banked #(.DW(8), .AW(16), .NBANK(4), .QDEPTH(QDEPTH)) dut (
        .CLK(CLK), .RSTN(RSTN), .ADDR(ADDR), .CE(CE), .CSB(CSB), .WEB(WEB), .OEB(OEB),
        .IDATA(IDATA), .RDY(RDY), .ODATA(ODATA), .ODATA_VLD(ODATA_VLD), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    // Reference model: each accepted command gets its issue edge scheduled at accept time:
    // no earlier than the next edge, and one extra edge after a same-bank predecessor.
    typedef struct { bit wr; logic [15:0] a; logic [7:0] d; int t; } cmd_t;
    typedef struct { int t; logic [7:0] d; bit k; } rd_t;
    typedef struct { int e; logic [7:0] d; } vl_t;
    cmd_t       q[$];
    rd_t        rq[$];
    vl_t        vlog[$];
    logic [7:0] mm [65536];
    bit         known [65536];
    int         edge_n = 0, last_t = -10, last_b = 0, rdy_low = 0;
    bit         e_err = 0, e_vld = 0, e_known = 1;
    logic [7:0] e_odata = '0;

    always @(posedge CLK or negedge RSTN) begin
        cmd_t c;
        rd_t  r;
        int   t, b;
        bit   ok, acc, ill;
        if (!RSTN) begin
            q.delete();
            rq.delete();
            e_err = 0; e_vld = 0; e_odata = '0; e_known = 1; last_t = -10;
        end else begin
            edge_n++;
            ok  = CE && !CSB && (q.size() < QDEPTH);
            acc = ok && (WEB != OEB);
            ill = ok && !WEB && !OEB;
            if (q.size() > 0 && q[0].t == edge_n) begin
                c = q.pop_front();
                if (c.wr) begin mm[c.a] = c.d; known[c.a] = 1; end
                else rq.push_back('{t: edge_n + 1, d: mm[c.a], k: known[c.a]});
            end
            e_vld = 0;
            if (rq.size() > 0 && rq[0].t == edge_n) begin
                r = rq.pop_front();
                e_vld = 1; e_odata = r.d; e_known = r.k;
            end
            if (acc) begin
                b = int'(ADDR[15:14]);
                t = last_t + 1 + ((b == last_b) ? 1 : 0);
                if (t < edge_n + 1) t = edge_n + 1;
                q.push_back('{wr: !WEB, a: ADDR, d: IDATA, t: t});
                last_t = t; last_b = b;
            end
            e_err = ill;
        end
    end

    always @(negedge CLK) begin
        chk("rdy", RDY, RSTN && q.size() < QDEPTH);
        chk("err", ERR, e_err);
        chk("vld", ODATA_VLD, e_vld);
        if (e_known) chk("odata", ODATA, e_odata);
        if (ODATA_VLD) vlog.push_back('{e: edge_n, d: ODATA});
        if (RSTN && !RDY) rdy_low++;
    end

    task automatic idle();
        CE = 0; CSB = 1; WEB = 1; OEB = 1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic cmd(input bit wr, input logic [15:0] a, input logic [7:0] d);
        int n = 0;
        CE = 1; CSB = 0; WEB = !wr; OEB = wr; ADDR = a; IDATA = d;
        @(negedge CLK);
        while (!RDY && n < 50) begin @(negedge CLK); n++; end
        if (!RDY) begin
            chk("cmd_rdy_timeout", RDY, 1);
            idle();
            return;
        end
        @(posedge CLK);
        #1;
        idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", n_err);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int t0;
        logic [7:0] exp4 [4];
        step(3);
        RSTN = 1;
        step(2);

        // Single write then read on an idle queue.
        cmd(1, 16'h0000, 8'hA5);
        step(3);
        vlog.delete();
        cmd(0, 16'h0000, 8'h00);
        t0 = edge_n;
        step(4);
        chk("t1_cnt", vlog.size(), 1);
        if (vlog.size() > 0) begin
            chk("t1_data", vlog[0].d, 8'hA5);
            chk("t1_lat", vlog[0].e, t0 + 2);
        end

        // Four banks back-to-back: reads complete on consecutive cycles.
        exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) cmd(1, {i[1:0], 14'h0}, exp4[i]);
        step(3);
        vlog.delete();
        cmd(0, 16'h0000, 0);
        t0 = edge_n;
        for (int i = 1; i < 4; i++) cmd(0, {i[1:0], 14'h0}, 0);
        step(6);
        chk("t2_cnt", vlog.size(), 4);
        for (int i = 0; i < 4 && i < vlog.size(); i++) begin
            chk("t2_data", vlog[i].d, exp4[i]);
            chk("t2_edge", vlog[i].e, t0 + 2 + i);
        end

        // Same bank back-to-back: one bubble between the two issues.
        cmd(1, 16'h0000, 8'h5A);
        cmd(1, 16'h0064, 8'hC3);
        step(4);
        vlog.delete();
        cmd(0, 16'h0000, 0);
        t0 = edge_n;
        cmd(0, 16'h0064, 0);
        step(6);
        chk("t3_cnt", vlog.size(), 2);
        if (vlog.size() == 2) begin
            chk("t3_d0", vlog[0].d, 8'h5A);
            chk("t3_d1", vlog[1].d, 8'hC3);
            chk("t3_e0", vlog[0].e, t0 + 2);
            chk("t3_e1", vlog[1].e, t0 + 4);
        end

        // Four same-bank writes held back-to-back fill the queue twice.
        rdy_low = 0;
        for (int i = 0; i < 4; i++) cmd(1, 16'h0100 + 16'(i), 8'h10 + 8'(i));
        step(8);
        chk("t4_rdy_low", rdy_low, 2);
        vlog.delete();
        for (int i = 0; i < 4; i++) cmd(0, 16'h0100 + 16'(i), 0);
        step(12);
        chk("t4_cnt", vlog.size(), 4);
        for (int i = 0; i < 4 && i < vlog.size(); i++) chk("t4_data", vlog[i].d, 8'h10 + 8'(i));

        // Illegal command pulses ERR and does not write; both-high is silently ignored.
        CE = 1; CSB = 0; WEB = 0; OEB = 0; ADDR = 16'h4000; IDATA = 8'hFF;
        @(posedge CLK); #1; idle();
        @(negedge CLK); chk("t5_err", ERR, 1);
        @(negedge CLK); chk("t5_err_off", ERR, 0);
        CE = 1; CSB = 0; WEB = 1; OEB = 1; ADDR = 16'h4000;
        @(posedge CLK); #1; idle();
        @(negedge CLK); chk("t5_ign", ERR, 0);
        step(2);
        vlog.delete();
        cmd(0, 16'h4000, 0);
        step(5);
        chk("t5_cnt", vlog.size(), 1);
        if (vlog.size() > 0) chk("t5_data", vlog[0].d, 8'h22);

        // Reset between read issue and data return.
        step(3);
        vlog.delete();
        cmd(0, 16'hC000, 0);
        @(posedge CLK); #1;
        RSTN = 0;
        #1;
        chk("t6_rdy", RDY, 0);
        chk("t6_vld", ODATA_VLD, 0);
        chk("t6_odata", ODATA, 0);
        step(2);
        RSTN = 1;
        #1;
        chk("t6_rdy_up", RDY, 1);
        step(4);
        chk("t6_no_vld", vlog.size(), 0);
        cmd(0, 16'hC000, 0);
        step(5);
        chk("t6_cnt", vlog.size(), 1);
        if (vlog.size() > 0) chk("t6_data", vlog[0].d, 8'h44);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int r;
            if ($urandom_range(0, 499) == 0) begin
                RSTN = 0;
                step(2);
                RSTN = 1;
            end
            r = $urandom_range(0, 9);
            CE    = $urandom_range(0, 7) != 0;
            CSB   = $urandom_range(0, 7) == 0;
            WEB   = !(r < 4 || r == 8);
            OEB   = !((r >= 4 && r < 8) || r == 8);
            ADDR  = ($urandom_range(0, 3) == 0) ? 16'($urandom) :
                    {2'($urandom_range(0, 3)), 14'($urandom_range(0, 3))};
            IDATA = 8'($urandom);
            step(1);
        end
        idle();
        step(10);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
